pipe_reg: RTL and testbench
===========================

# pipe_reg

Parametrised Y86-64 inter-stage pipeline register: one instance serves each of the F→D, D→E, E→M and M→W boundaries. It captures an instruction's status, icode/ifun, register identifiers and 64-bit values on each clock. It also implements the hazard controls the PIPE control logic drives: stall (hold) and bubble (inject NOP). On top of that it adds an optional sticky-exception freeze for the W boundary and saturating stall/bubble event counters for performance analysis.

## Interface
Parameters:
- NREGS, 2: number of 4-bit register-id fields carried (rA, rB, dstE, dstM, srcA, ...).
- NVALS, 2: number of 64-bit value fields carried (valC, valP, valE, valM, valA, ...).
- CNT_W, 32: width of each event counter.
- STICKY_EXC, 0: 1 = freeze contents once an exception status is held (W-stage behaviour).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hold current contents.
- bubble  in  1  load a NOP bubble.
- in_stat  in  3  incoming status.
- in_icode  in  4  incoming instruction code.
- in_ifun  in  4  incoming function code.
- in_regs  in  4*NREGS  register ids; field k = bits [4k+3:4k].
- in_vals  in  64*NVALS  values; field k = bits [64k+63:64k].
- out_stat, out_icode, out_ifun, out_regs, out_vals  out  same widths  registered contents.
- out_valid  out  1  1 when out_stat != STAT_BUB.
- frozen  out  1  sticky-exception freeze active.
- ctl_err  out  1  registered one-cycle pulse: stall and bubble asserted together.
- stall_cnt  out  CNT_W  count of cycles that performed a stall.
- bubble_cnt  out  CNT_W  count of cycles that performed a bubble.

## Operation
- Action per cycle, priority order: reset > freeze > bubble > stall > load.
- Reset (rst_n=0 at edge) loads the bubble state, clears frozen, ctl_err and both counters.
- Bubble state: stat=STAT_BUB (0), icode=I_NOP (1), ifun=0, every reg field=RNONE (4'hF), every value=0.
- Load: all fields copy the inputs unchanged.
- Stall: all fields hold. stall_cnt increments.
- Bubble: load the bubble state. bubble_cnt increments.
- stall and bubble both high: bubble wins and bubble_cnt increments; stall_cnt does not. ctl_err=1 on the following cycle.
- Freeze (STICKY_EXC=1 only): frozen is set on the edge at which the loaded stat ∈ {STAT_HLT, STAT_ADR, STAT_INS}. While frozen, all fields hold and stall/bubble are ignored. Counters do not increment, and ctl_err still reports conflicts. Only reset clears frozen.
- With STICKY_EXC=0, frozen is constant 0.
- Counters saturate at 2^CNT_W−1; they never wrap.
- in_stat values outside 0–4 are passed through unchanged. out_valid is derived only from out_stat.

## Timing
- Latency one cycle: inputs sampled at edge N appear on outputs after edge N.
- All outputs are registered except out_valid, which is combinational from out_stat.
- No handshake. stall/bubble are sampled at the same edge as the data.
- Reset asserted mid-stall or mid-freeze takes effect at that edge. The first load can happen at the first edge with rst_n=1.
- Counter increment is visible the cycle after the stall/bubble edge.

## Structure
- Shared package y86_pkg holds:
  - STAT_BUB=0, STAT_AOK=1, STAT_HLT=2, STAT_ADR=3, STAT_INS=4 (3-bit).
  - I_NOP=4'h1, RNONE=4'hF.
  - The stat/icode typedefs, shared with fetch, decode and control logic.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), is instantiated twice.
- The field array and bubble mux stay in pipe_reg.

## Test plan
- Reset: hold rst_n=0 one edge with inputs non-zero → out_stat=0, icode=1, regs all 4'hF, vals 0, out_valid=0, counters 0.
- Load: stat=1, icode=6, ifun=1, regs={4'h2,4'h3}, vals={64'h10,64'h1A} → identical values on outputs next cycle, out_valid=1.
- Stall three cycles while inputs change → outputs unchanged for those cycles; stall_cnt=3.
- Bubble and stall together for one cycle → bubble state loaded, bubble_cnt=1, stall_cnt unchanged, ctl_err high exactly one cycle.
- STICKY_EXC=1: load stat=3 (ADR), then drive new data and bubble → frozen=1, outputs hold the ADR instruction, counters static; rst_n=0 clears frozen.
- CNT_W=4: stall 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: status codes, instruction codes, register ids.
// Fetch, decode, control and the inter-stage registers all import this package.
package y86_pkg;

  typedef logic [2:0] stat_t;
  typedef logic [3:0] icode_t;
  typedef logic [3:0] regid_t;

  localparam stat_t  STAT_BUB = 3'd0;
  localparam stat_t  STAT_AOK = 3'd1;
  localparam stat_t  STAT_HLT = 3'd2;
  localparam stat_t  STAT_ADR = 3'd3;
  localparam stat_t  STAT_INS = 3'd4;

  localparam icode_t I_NOP    = 4'h1;
  localparam regid_t RNONE    = 4'hF;

  // True for the status codes that stop the machine once they retire.
  function automatic logic is_exc(input stat_t s);
    logic r;
    case (s)
      STAT_HLT, STAT_ADR, STAT_INS: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// Bundle of the hazard controls, stage payload and status/counter outputs of one
// inter-stage pipeline register; the register itself attaches through the slave modport.
interface pipe_reg_if
  import y86_pkg::*;
#(
  parameter int NREGS = 2,
  parameter int NVALS = 2,
  parameter int CNT_W = 32
);

  logic                  stall;
  logic                  bubble;
  stat_t                 in_stat;
  icode_t                in_icode;
  logic [3:0]            in_ifun;
  logic [4*NREGS-1:0]    in_regs;
  logic [64*NVALS-1:0]   in_vals;

  stat_t                 out_stat;
  icode_t                out_icode;
  logic [3:0]            out_ifun;
  logic [4*NREGS-1:0]    out_regs;
  logic [64*NVALS-1:0]   out_vals;
  logic                  out_valid;
  logic                  frozen;
  logic                  ctl_err;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      bubble_cnt;

  modport master (
    output stall, bubble, in_stat, in_icode, in_ifun, in_regs, in_vals,
    input  out_stat, out_icode, out_ifun, out_regs, out_vals, out_valid,
           frozen, ctl_err, stall_cnt, bubble_cnt
  );

  modport slave (
    input  stall, bubble, in_stat, in_icode, in_ifun, in_regs, in_vals,
    output out_stat, out_icode, out_ifun, out_regs, out_vals, out_valid,
           frozen, ctl_err, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/pipe_reg_sat_counter.sv
// Event counter that sticks at its all-ones ceiling instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: advance on an event unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_reg.sv
// Y86-64 inter-stage pipeline register with stall/bubble control, optional sticky
// exception freeze (W boundary) and saturating stall/bubble event counters.
module pipe_reg
  import y86_pkg::*;
#(
  parameter int NREGS      = 2,
  parameter int NVALS      = 2,
  parameter int CNT_W      = 32,
  parameter bit STICKY_EXC = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_reg_if.slave  bus
);

  typedef struct packed {
    stat_t               stat;
    icode_t              icode;
    logic [3:0]          ifun;
    logic [4*NREGS-1:0]  regs;
    logic [64*NVALS-1:0] vals;
  } fields_t;

  fields_t fields_q;
  fields_t fields_d;
  fields_t bubble_fields_s;
  fields_t in_fields_s;
  logic    frozen_q;
  logic    frozen_d;
  logic    ctl_err_q;
  logic    ctl_err_d;
  logic    stall_inc_s;
  logic    bubble_inc_s;

  assign bubble_fields_s = '{stat:  STAT_BUB,
                             icode: I_NOP,
                             ifun:  4'h0,
                             regs:  {NREGS{RNONE}},
                             vals:  {(64*NVALS){1'b0}}};

  assign in_fields_s = '{stat:  bus.in_stat,
                         icode: bus.in_icode,
                         ifun:  bus.in_ifun,
                         regs:  bus.in_regs,
                         vals:  bus.in_vals};

  // Action select: freeze > bubble > stall > load; conflicts flagged regardless.
  always_comb begin
    fields_d     = fields_q;
    frozen_d     = frozen_q;
    stall_inc_s  = 1'b0;
    bubble_inc_s = 1'b0;
    ctl_err_d    = bus.stall & bus.bubble;
    if (frozen_q) begin
      fields_d = fields_q;
    end else if (bus.bubble) begin
      fields_d     = bubble_fields_s;
      bubble_inc_s = 1'b1;
    end else if (bus.stall) begin
      fields_d    = fields_q;
      stall_inc_s = 1'b1;
    end else begin
      fields_d = in_fields_s;
      frozen_d = STICKY_EXC && is_exc(bus.in_stat);
    end
  end

  // Payload, freeze flag and conflict pulse registers; reset loads the bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fields_q  <= bubble_fields_s;
      frozen_q  <= 1'b0;
      ctl_err_q <= 1'b0;
    end else begin
      fields_q  <= fields_d;
      frozen_q  <= frozen_d;
      ctl_err_q <= ctl_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_inc_s),
    .count (bus.bubble_cnt)
  );

  assign bus.out_stat  = fields_q.stat;
  assign bus.out_icode = fields_q.icode;
  assign bus.out_ifun  = fields_q.ifun;
  assign bus.out_regs  = fields_q.regs;
  assign bus.out_vals  = fields_q.vals;
  assign bus.out_valid = (fields_q.stat != STAT_BUB);
  assign bus.frozen    = frozen_q;
  assign bus.ctl_err   = ctl_err_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Drives one directed stimulus stream into three pipe_reg variants (plain, sticky
// exception, 4-bit counters) and checks each against a rule-level model every cycle.
module tb_pipe_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         bubble;
  logic [2:0]   in_stat;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [7:0]   in_regs;
  logic [127:0] in_vals;

  int checks   = 0;
  int failures = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  pipe_reg_if #(.NREGS(2), .NVALS(2), .CNT_W(32)) if0 ();
  pipe_reg_if #(.NREGS(2), .NVALS(2), .CNT_W(32)) if1 ();
  pipe_reg_if #(.NREGS(2), .NVALS(2), .CNT_W(4))  if2 ();

  assign if0.stall = stall;  assign if0.bubble = bubble;
  assign if0.in_stat = in_stat;  assign if0.in_icode = in_icode;
  assign if0.in_ifun = in_ifun;  assign if0.in_regs = in_regs;  assign if0.in_vals = in_vals;
  assign if1.stall = stall;  assign if1.bubble = bubble;
  assign if1.in_stat = in_stat;  assign if1.in_icode = in_icode;
  assign if1.in_ifun = in_ifun;  assign if1.in_regs = in_regs;  assign if1.in_vals = in_vals;
  assign if2.stall = stall;  assign if2.bubble = bubble;
  assign if2.in_stat = in_stat;  assign if2.in_icode = in_icode;
  assign if2.in_ifun = in_ifun;  assign if2.in_regs = in_regs;  assign if2.in_vals = in_vals;

  pipe_reg #(.NREGS(2), .NVALS(2), .CNT_W(32), .STICKY_EXC(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pipe_reg #(.NREGS(2), .NVALS(2), .CNT_W(32), .STICKY_EXC(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipe_reg #(.NREGS(2), .NVALS(2), .CNT_W(4),  .STICKY_EXC(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [7:0]   regs;
    logic [127:0] vals;
    bit           frozen;
    bit           ctl;
    longint       sc;
    longint       bc;
  } mst_t;

  mst_t   m [3];
  bit     sticky [3] = '{1'b0, 1'b1, 1'b0};
  longint cmax   [3] = '{64'd4294967295, 64'd4294967295, 64'd15};

  // Next model state from the current inputs, applying the action priority rules.
  function automatic mst_t mstep(input mst_t s, input bit stk, input longint mx);
    mst_t n = s;
    if (!rst_n) begin
      n.stat = 3'd0; n.icode = 4'd1; n.ifun = 4'd0; n.regs = 8'hFF; n.vals = '0;
      n.frozen = 1'b0; n.ctl = 1'b0; n.sc = 0; n.bc = 0;
    end else begin
      n.ctl = stall && bubble;
      if (stk && s.frozen) begin
        n.frozen = 1'b1;
      end else if (bubble) begin
        n.stat = 3'd0; n.icode = 4'd1; n.ifun = 4'd0; n.regs = 8'hFF; n.vals = '0;
        if (s.bc < mx) n.bc = s.bc + 1;
      end else if (stall) begin
        if (s.sc < mx) n.sc = s.sc + 1;
      end else begin
        n.stat = in_stat; n.icode = in_icode; n.ifun = in_ifun;
        n.regs = in_regs; n.vals = in_vals;
        n.frozen = stk && (in_stat == 3'd2 || in_stat == 3'd3 || in_stat == 3'd4);
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ifn,
                     input logic [7:0] rg, input logic [127:0] vl, input logic vd, input logic fz,
                     input logic ce, input longint sc, input longint bc);
    chk($sformatf("u%0d.stat", k), 128'(st), 128'(m[k].stat));
    chk($sformatf("u%0d.icode", k), 128'(ic), 128'(m[k].icode));
    chk($sformatf("u%0d.ifun", k), 128'(ifn), 128'(m[k].ifun));
    chk($sformatf("u%0d.regs", k), 128'(rg), 128'(m[k].regs));
    chk($sformatf("u%0d.vals", k), vl, m[k].vals);
    chk($sformatf("u%0d.valid", k), 128'(vd), 128'(m[k].stat != 3'd0));
    chk($sformatf("u%0d.frozen", k), 128'(fz), 128'(m[k].frozen));
    chk($sformatf("u%0d.ctl_err", k), 128'(ce), 128'(m[k].ctl));
    chk($sformatf("u%0d.stall_cnt", k), 128'(sc), 128'(m[k].sc));
    chk($sformatf("u%0d.bubble_cnt", k), 128'(bc), 128'(m[k].bc));
  endtask

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (model_on) begin
      cmp(0, if0.out_stat, if0.out_icode, if0.out_ifun, if0.out_regs, if0.out_vals, if0.out_valid,
          if0.frozen, if0.ctl_err, longint'(if0.stall_cnt), longint'(if0.bubble_cnt));
      cmp(1, if1.out_stat, if1.out_icode, if1.out_ifun, if1.out_regs, if1.out_vals, if1.out_valid,
          if1.frozen, if1.ctl_err, longint'(if1.stall_cnt), longint'(if1.bubble_cnt));
      cmp(2, if2.out_stat, if2.out_icode, if2.out_ifun, if2.out_regs, if2.out_vals, if2.out_valid,
          if2.frozen, if2.ctl_err, longint'(if2.stall_cnt), longint'(if2.bubble_cnt));
    end
  end

  task automatic drive(input logic r, input logic st, input logic bu, input logic [2:0] s,
                       input logic [3:0] ic, input logic [3:0] fn, input logic [7:0] rg,
                       input logic [127:0] vl);
    rst_n = r; stall = st; bubble = bu; in_stat = s; in_icode = ic;
    in_ifun = fn; in_regs = rg; in_vals = vl;
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], sticky[i], cmax[i]);
    model_on = 1'b1;
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'd6, 4'd1, 8'h23, {64'h10, 64'h1A});
    step();
    chk("rst.stat", 128'(if0.out_stat), 128'd0);
    chk("rst.icode", 128'(if0.out_icode), 128'd1);
    chk("rst.regs", 128'(if0.out_regs), 128'hFF);
    chk("rst.vals", if0.out_vals, 128'd0);
    chk("rst.valid", 128'(if0.out_valid), 128'd0);
    chk("rst.cnt", 128'(if0.stall_cnt) + 128'(if0.bubble_cnt), 128'd0);

    drive(1'b1, 1'b0, 1'b0, 3'd1, 4'd6, 4'd1, 8'h23, {64'h10, 64'h1A});
    step();
    chk("load.icode", 128'(if0.out_icode), 128'd6);
    chk("load.regs", 128'(if0.out_regs), 128'h23);
    chk("load.vals", if0.out_vals, {64'h10, 64'h1A});
    chk("load.valid", 128'(if0.out_valid), 128'd1);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd1, 4'(i + 2), 4'(i), 8'(8'h40 + i), 128'(i * 7 + 3));
      step();
    end
    chk("stall.regs", 128'(if0.out_regs), 128'h23);
    chk("stall.cnt", 128'(if0.stall_cnt), 128'd3);

    drive(1'b1, 1'b1, 1'b1, 3'd1, 4'd2, 4'd0, 8'h45, 128'h99);
    step();
    chk("conf.stat", 128'(if0.out_stat), 128'd0);
    chk("conf.bcnt", 128'(if0.bubble_cnt), 128'd1);
    chk("conf.scnt", 128'(if0.stall_cnt), 128'd3);
    chk("conf.ctl", 128'(if0.ctl_err), 128'd1);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 4'd3, 4'd0, 8'h01, 128'h5);
    step();
    chk("conf.ctl_drop", 128'(if0.ctl_err), 128'd0);

    drive(1'b1, 1'b0, 1'b0, 3'd3, 4'd5, 4'd0, 8'h7F, {64'h1000, 64'h8});
    step();
    chk("adr.frozen1", 128'(if1.frozen), 128'd1);
    chk("adr.frozen0", 128'(if0.frozen), 128'd0);
    drive(1'b1, 1'b0, 1'b1, 3'd1, 4'd6, 4'd2, 8'h12, 128'hABC);
    step();
    chk("frz.stat", 128'(if1.out_stat), 128'd3);
    chk("frz.vals", if1.out_vals, {64'h1000, 64'h8});
    chk("frz.bcnt", 128'(if1.bubble_cnt), 128'd1);
    chk("frz.u0stat", 128'(if0.out_stat), 128'd0);
    drive(1'b1, 1'b1, 1'b1, 3'd1, 4'd6, 4'd2, 8'h12, 128'hABC);
    step();
    chk("frz.ctl", 128'(if1.ctl_err), 128'd1);
    chk("frz.scnt", 128'(if1.stall_cnt), 128'd3);
    drive(1'b0, 1'b1, 1'b0, 3'd1, 4'd6, 4'd2, 8'h12, 128'hABC);
    step();
    chk("frz.clear", 128'(if1.frozen), 128'd0);

    drive(1'b1, 1'b0, 1'b0, 3'd7, 4'd0, 4'd3, 8'h9A, 128'h77);
    step();
    chk("odd.stat", 128'(if0.out_stat), 128'd7);
    chk("odd.valid", 128'(if0.out_valid), 128'd1);
    chk("odd.nofrz", 128'(if1.frozen), 128'd0);

    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'(i % 5), 4'(i), 4'(i + 1), 8'(i * 3), 128'(i));
      step();
    end
    chk("sat.cnt4", 128'(if2.stall_cnt), 128'd15);
    chk("sat.cnt32", 128'(if0.stall_cnt), 128'd20);

    drive(1'b1, 1'b0, 1'b1, 3'd1, 4'd0, 4'd0, 8'h00, 128'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd4, 4'd1, 4'd0, 8'h3C, 128'h1);
    step();
    chk("ins.frozen", 128'(if1.frozen), 128'd1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
